// File: rtl/i2s_audio_tx.sv
// I2S transmitter: one-pair holding register in front of a frame shift register,
// BCLK/LRCK derived from free-running counters, everything idle until PLL lock.
module i2s_audio_tx #(
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned SLOT_WIDTH   = 32,
  parameter int unsigned BCLK_DIV     = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pll_locked,
  input  logic [SAMPLE_WIDTH-1:0] sample_left,
  input  logic [SAMPLE_WIDTH-1:0] sample_right,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  output logic                    i2s_bclk,
  output logic                    i2s_lrck,
  output logic                    i2s_sdata,
  output logic                    underrun
);

  localparam int unsigned FrameBits = 2 * SLOT_WIDTH;
  localparam int unsigned DivW      = $clog2(BCLK_DIV);
  localparam int unsigned BitW      = $clog2(FrameBits);
  localparam int unsigned PadW      = SLOT_WIDTH - SAMPLE_WIDTH;

  localparam logic [DivW-1:0] DivLast   = DivW'(BCLK_DIV - 1);
  localparam logic [DivW-1:0] DivHalf   = DivW'(BCLK_DIV / 2);
  localparam logic [BitW-1:0] SlotStart = BitW'(SLOT_WIDTH);

  logic lock_meta_q, run_q;

  logic [DivW-1:0]         div_cnt_q, div_cnt_d;
  logic [BitW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [FrameBits-1:0]    shreg_q, shreg_d;
  logic [SAMPLE_WIDTH-1:0] hold_left_q, hold_left_d;
  logic [SAMPLE_WIDTH-1:0] hold_right_q, hold_right_d;
  logic                    hold_full_q, hold_full_d;
  logic                    underrun_q, underrun_d;

  logic                    fall_evt, load_evt, xfer;
  logic [SLOT_WIDTH-1:0]   left_slot, right_slot;

  // Two-flop synchronizer for the asynchronous PLL lock; run_q qualifies the datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta_q <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      lock_meta_q <= pll_locked;
      run_q       <= lock_meta_q;
    end
  end

  // Samples are MSB-aligned in their slot, zero padded below.
  assign left_slot  = SLOT_WIDTH'(hold_left_q) << PadW;
  assign right_slot = SLOT_WIDTH'(hold_right_q) << PadW;

  // Falling-edge event is the div_cnt wrap; the load sits on the wrap that makes bit_cnt 1.
  assign fall_evt = (div_cnt_q == DivLast);
  assign load_evt = fall_evt && (bit_cnt_q == '0);
  assign xfer     = sample_valid && sample_ready;

  // Next-state logic: counters, shift/load, holding register handshake.
  always_comb begin
    div_cnt_d    = div_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    hold_left_d  = hold_left_q;
    hold_right_d = hold_right_q;
    hold_full_d  = hold_full_q;
    underrun_d   = 1'b0;

    if (!run_q) begin
      // Lock lost or not yet acquired: abort the frame and drop any pending pair.
      div_cnt_d    = '0;
      bit_cnt_d    = '0;
      shreg_d      = '0;
      hold_left_d  = '0;
      hold_right_d = '0;
      hold_full_d  = 1'b0;
    end else begin
      div_cnt_d = fall_evt ? '0 : div_cnt_q + 1'b1;
      if (fall_evt) begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end

      if (load_evt) begin
        if (hold_full_q) begin
          shreg_d     = {left_slot, right_slot};
          hold_full_d = 1'b0;
        end else begin
          shreg_d    = '0;
          underrun_d = 1'b1;
        end
      end else if (fall_evt) begin
        shreg_d = {shreg_q[FrameBits-2:0], 1'b0};
      end

      // A transfer needs ready, so holding is empty and cannot collide with a full load.
      if (xfer) begin
        hold_left_d  = sample_left;
        hold_right_d = sample_right;
        hold_full_d  = 1'b1;
      end
    end
  end

  // Datapath state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      hold_left_q  <= '0;
      hold_right_q <= '0;
      hold_full_q  <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      hold_left_q  <= hold_left_d;
      hold_right_q <= hold_right_d;
      hold_full_q  <= hold_full_d;
      underrun_q   <= underrun_d;
    end
  end

  // Outputs gated by run so they drop as soon as the synchronized lock falls.
  always_comb begin
    sample_ready = run_q && !hold_full_q;
    i2s_bclk     = run_q && (div_cnt_q >= DivHalf);
    i2s_lrck     = run_q && (bit_cnt_q >= SlotStart);
    i2s_sdata    = run_q && shreg_q[FrameBits-1];
    underrun     = run_q && underrun_q;
  end

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Bench for i2s_audio_tx: a default instance and a 24-bit-sample instance share
// clock, reset, lock and valid; a time-based model predicts every output each cycle.
module tb_i2s_audio_tx;

  localparam int DIV   = 8;
  localparam int SLOT  = 32;
  localparam int FRAME = 2 * SLOT * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pll_locked = 1'b0;
  logic        sample_valid = 1'b0;
  logic [15:0] sl = '0, sr = '0;
  logic [23:0] sl24 = '0, sr24 = '0;

  logic ready_a, bclk_a, lrck_a, sdata_a, ur_a;
  logic ready_b, bclk_b, lrck_b, sdata_b, ur_b;

  always #5 clk = ~clk;

  i2s_audio_tx dut_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .pll_locked  (pll_locked),
    .sample_left (sl),
    .sample_right(sr),
    .sample_valid(sample_valid),
    .sample_ready(ready_a),
    .i2s_bclk    (bclk_a),
    .i2s_lrck    (lrck_a),
    .i2s_sdata   (sdata_a),
    .underrun    (ur_a)
  );

  i2s_audio_tx #(.SAMPLE_WIDTH(24)) dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .pll_locked  (pll_locked),
    .sample_left (sl24),
    .sample_right(sr24),
    .sample_valid(sample_valid),
    .sample_ready(ready_b),
    .i2s_bclk    (bclk_b),
    .i2s_lrck    (lrck_b),
    .i2s_sdata   (sdata_b),
    .underrun    (ur_b)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // ---------------- behavioural model ----------------
  // m_t counts clk edges since run rose; everything else is derived from it.
  logic        m_sync1 = 1'b0, m_run = 1'b0, m_full = 1'b0;
  int          m_t = -1, m_ur_t = -1;
  logic [15:0] m_hl = '0, m_hr = '0;
  logic [23:0] m_hl24 = '0, m_hr24 = '0;
  logic [63:0] m_frame = '0, m_frame24 = '0;

  always @(posedge clk or negedge rst_n) begin
    logic old_run, xfer;
    if (!rst_n) begin
      m_sync1 = 1'b0; m_run = 1'b0; m_full = 1'b0; m_t = -1; m_ur_t = -1;
      m_frame = '0; m_frame24 = '0;
    end else begin
      old_run = m_run;
      xfer    = sample_valid && m_run && !m_full;
      m_run   = m_sync1;
      m_sync1 = pll_locked;
      if (!m_run) begin
        m_t = -1; m_ur_t = -1; m_full = 1'b0; m_frame = '0; m_frame24 = '0;
      end else begin
        m_t = old_run ? m_t + 1 : 0;
        if (m_t >= DIV && (m_t - DIV) % FRAME == 0) begin
          if (m_full) begin
            m_frame   = {m_hl, 16'h0, m_hr, 16'h0};
            m_frame24 = {m_hl24, 8'h0, m_hr24, 8'h0};
            m_full    = 1'b0;
          end else begin
            m_frame = '0; m_frame24 = '0; m_ur_t = m_t;
          end
        end
        if (xfer) begin
          m_hl = sl; m_hr = sr; m_hl24 = sl24; m_hr24 = sr24; m_full = 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic e_bclk, e_lrck, e_sa, e_sb, e_rdy, e_ur;
    int k;
    e_bclk = 0; e_lrck = 0; e_sa = 0; e_sb = 0; e_rdy = 0; e_ur = 0;
    if (m_run) begin
      e_bclk = (m_t % DIV) >= DIV / 2;
      e_lrck = ((m_t / DIV) % 64) >= SLOT;
      if (m_t >= DIV) begin
        k    = ((m_t - DIV) / DIV) % 64;
        e_sa = m_frame[63-k];
        e_sb = m_frame24[63-k];
      end
      e_rdy = !m_full;
      e_ur  = (m_t == m_ur_t);
    end
    check("bclk_a", bclk_a, e_bclk);
    check("lrck_a", lrck_a, e_lrck);
    check("sdata_a", sdata_a, e_sa);
    check("ready_a", ready_a, e_rdy);
    check("underrun_a", ur_a, e_ur);
    check("bclk_b", bclk_b, e_bclk);
    check("lrck_b", lrck_b, e_lrck);
    check("sdata_b", sdata_b, e_sb);
    check("ready_b", ready_b, e_rdy);
    check("underrun_b", ur_b, e_ur);
  end

  // Underrun pulse and idle-data monitors for the directed literal checks.
  int ur_cnt = 0, ur_last = -1, ur_gap = 0, ones_cnt = 0;
  always @(negedge clk) begin
    if (ur_a) begin
      ur_cnt++;
      ur_gap  = cyc - ur_last;
      ur_last = cyc;
    end
    if (sdata_a) ones_cnt++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [15:0] l, input logic [15:0] r,
                      input logic [23:0] l24, input logic [23:0] r24, output bit ok);
    sl = l; sr = r; sl24 = l24; sr24 = r24;
    sample_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (ready_a) begin
        ok = 1;
        @(posedge clk);
        #1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("send_timeout", ok, 1);
  endtask

  task automatic next_rise(output bit ok);
    logic p;
    p  = bclk_a;
    ok = 0;
    for (int i = 0; i < 4 * DIV; i++) begin
      @(negedge clk);
      if (bclk_a && !p) begin
        ok = 1;
        break;
      end
      p = bclk_a;
    end
  endtask

  task automatic wait_lrck_fall(output bit ok);
    logic p;
    p  = lrck_a;
    ok = 0;
    for (int i = 0; i < FRAME + 4 * DIV; i++) begin
      @(negedge clk);
      if (!lrck_a && p) begin
        ok = 1;
        break;
      end
      p = lrck_a;
    end
    if (!ok) check("lrck_fall_timeout", ok, 1);
  endtask

  // Sample 64 consecutive BCLK rising edges; bit index 0 lands in [63].
  task automatic capture(output logic [63:0] ca, output logic [63:0] cb);
    bit ok;
    ca = '0; cb = '0;
    for (int i = 0; i < 64; i++) begin
      next_rise(ok);
      if (!ok) begin
        check("bclk_rise_timeout", ok, 1);
        break;
      end
      ca[63-i] = sdata_a;
      cb[63-i] = sdata_b;
    end
  endtask

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    bit          ok;
    logic [63:0] ca, cb;
    int          n, snap;
    logic [15:0] pl[4], pr[4];

    repeat (3) @(negedge clk);
    check("rst_bclk", bclk_a, 0);
    check("rst_lrck", lrck_a, 0);
    check("rst_sdata", sdata_a, 0);
    check("rst_ready", ready_a, 0);
    check("rst_underrun", ur_a, 0);
    rst_n = 1'b1;

    repeat (100) @(negedge clk);
    check("unlocked_ready", ready_a, 0);
    check("unlocked_bclk", bclk_a, 0);

    // Lock: ready after two synchronizer stages, then the known pattern.
    pll_locked = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready_a && n < 10);
    check("ready_latency", n, 2);
    snap = ur_cnt;
    send(16'hA5C3, 16'h1234, 24'h800001, 24'hFEDCBA, ok);
    sample_valid = 1'b0;
    capture(ca, cb);
    check("left_bits_1_16", ca[62:47], 16'hA5C3);
    check("left_pad", ca[46:31], 16'h0000);
    check("right_bits_33_48", ca[30:15], 16'h1234);
    check("right_pad", ca[14:0], 15'h0);
    check("wide_left", cb[62:39], 24'h800001);
    check("wide_left_pad", cb[38:31], 8'h00);
    check("wide_right", cb[30:7], 24'hFEDCBA);
    check("first_frame_underrun", ur_cnt - snap, 0);

    // Starvation for three frames.
    snap = ur_cnt;
    ones_cnt = 0;
    repeat (3 * FRAME) @(negedge clk);
    check("underrun_count", ur_cnt - snap, 3);
    check("underrun_gap", ur_gap, FRAME);
    check("idle_sdata_ones", ones_cnt, 0);

    // Backpressure: valid held high across four pairs.
    for (int p = 0; p < 4; p++) begin
      pl[p] = 16'($urandom);
      pr[p] = 16'($urandom);
    end
    wait_lrck_fall(ok);
    repeat (2 * DIV) @(negedge clk);
    snap = ur_cnt;
    for (int p = 0; p < 4; p++) begin
      send(pl[p], pr[p], 24'($urandom), 24'($urandom), ok);
    end
    sample_valid = 1'b0;
    wait_lrck_fall(ok);
    capture(ca, cb);
    check("bp_last_left", ca[62:47], pl[3]);
    check("bp_last_right", ca[30:15], pr[3]);
    check("bp_no_underrun", ur_cnt - snap, 0);

    // Lock loss at bit_cnt 20 with a pair pending.
    wait_lrck_fall(ok);
    repeat (3 * DIV) @(negedge clk);
    send(16'hFFFF, 16'hFFFF, 24'hFFFFFF, 24'hFFFFFF, ok);
    sample_valid = 1'b0;
    n = 0;
    while (((m_t / DIV) % 64) != 20 && n < FRAME) begin
      @(negedge clk);
      n++;
    end
    pll_locked = 1'b0;
    repeat (3) @(negedge clk);
    check("lost_bclk", bclk_a, 0);
    check("lost_lrck", lrck_a, 0);
    check("lost_sdata", sdata_a, 0);
    check("lost_ready", ready_a, 0);
    repeat (20) @(negedge clk);
    pll_locked = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready_a && n < 10);
    check("relock_ready_latency", n, 2);
    snap = ur_cnt;
    capture(ca, cb);
    check("relock_frame_a", ca, 64'h0);
    check("relock_frame_b", cb, 64'h0);
    check("relock_underrun", ur_cnt - snap, 1);

    // Random traffic; data lines churn every cycle regardless of valid.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      sample_valid = ($urandom_range(0, 2) == 0);
      sl   = 16'($urandom);
      sr   = 16'($urandom);
      sl24 = 24'($urandom);
      sr24 = 24'($urandom);
    end
    sample_valid = 1'b0;
    repeat (10) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
